alu_issue_stage: RTL and testbench

//  Decode/issue stage that feeds the RV32I ALU. Accepts instruction words over valid/ready.

---
 rtl/alu_issue_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes OP/OP-IMM/BRANCH into an ALU command behind a
// registered output plus one skid entry. Optional perf counters under ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
`ifdef ALU_ISSUE_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_fn,
  output logic [XLEN-1:0] operandA,
  output logic [XLEN-1:0] operandB,
  output logic            bneq,
  output logic            btype,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
  , output logic [PERF_W-1:0] perf_issued
  , output logic [PERF_W-1:0] perf_stalled
`endif
);

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SLL  = 4'd1;
  localparam logic [3:0] FN_SLT  = 4'd2;
  localparam logic [3:0] FN_SLTU = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_SRL  = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_AND  = 4'd7;
  localparam logic [3:0] FN_SUB  = 4'd8;
  localparam logic [3:0] FN_BGE  = 4'd9;
  localparam logic [3:0] FN_BGEU = 4'd10;
  localparam logic [3:0] FN_SRA  = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]      fn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            bneq;
    logic            btype;
    logic [4:0]      rd;
    logic            wb_en;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } cmd_t;

  // Register-register / register-immediate function mapping shared by OP and OP-IMM
  function automatic logic [3:0] op_fn(input logic [2:0] f3, input logic alt);
    logic [3:0] fn;
    case (f3)
      3'b000:  fn = alt ? FN_SUB : FN_ADD;
      3'b001:  fn = FN_SLL;
      3'b010:  fn = FN_SLT;
      3'b011:  fn = FN_SLTU;
      3'b100:  fn = FN_XOR;
      3'b101:  fn = alt ? FN_SRA : FN_SRL;
      3'b110:  fn = FN_OR;
      default: fn = FN_AND;
    endcase
    return fn;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_field;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] shamt;
  logic            legal;
  logic            writes_rd;
  cmd_t            dec;

  cmd_t out_q;
  cmd_t skid_q;
  logic out_valid_q;
  logic skid_valid_q;
  logic accept;
  logic drain;

  assign opcode   = in_instr[6:0];
  assign rd_field = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign rs1_val  = (rs1_addr == 5'd0) ? '0 : rs1_data;
  assign rs2_val  = (rs2_addr == 5'd0) ? '0 : rs2_data;
  assign imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign shamt    = XLEN'(in_instr[24:20]);

  // Decode; anything unrecognised collapses to a zeroed ADD flagged illegal
  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal     = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        writes_rd = 1'b1;
        dec.fn    = op_fn(funct3, funct7[5]);
        dec.a     = rs1_val;
        dec.b     = rs2_val;
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        dec.a     = rs1_val;
        case (funct3)
          3'b001: begin
            legal  = (funct7 == 7'h00);
            dec.fn = FN_SLL;
            dec.b  = shamt;
          end
          3'b101: begin
            legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
            dec.fn = funct7[5] ? FN_SRA : FN_SRL;
            dec.b  = shamt;
          end
          default: begin
            legal  = 1'b1;
            dec.fn = op_fn(funct3, 1'b0);
            dec.b  = imm_i;
          end
        endcase
      end
      OPC_BRANCH: begin
        legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec.btype = 1'b1;
        dec.a     = rs1_val;
        dec.b     = rs2_val;
        case (funct3)
          3'b000:  dec.fn = FN_SUB;
          3'b001: begin
            dec.fn   = FN_SUB;
            dec.bneq = 1'b1;
          end
          3'b100:  dec.fn = FN_SLT;
          3'b101:  dec.fn = FN_BGE;
          3'b110:  dec.fn = FN_SLTU;
          3'b111:  dec.fn = FN_BGEU;
          default: dec.fn = FN_ADD;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else if (writes_rd && (rd_field != 5'd0)) begin
      dec.wb_en = 1'b1;
      dec.rd    = rd_field;
    end
    dec.pc = in_pc;
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q && !flush;
  assign drain    = out_valid_q && out_ready;

  // Output register plus skid; skid always drains ahead of new input to keep order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_fn      = out_q.fn;
  assign operandA    = out_q.a;
  assign operandB    = out_q.b;
  assign bneq        = out_q.bneq;
  assign btype       = out_q.btype;
  assign out_rd      = out_q.rd;
  assign out_wb_en   = out_q.wb_en;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
  // Free-running wrap-around counters; flush leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued  <= '0;
      perf_stalled <= '0;
    end else begin
      if (drain) perf_issued <= perf_issued + PERF_W'(1);
      if (out_valid_q && !out_ready) perf_stalled <= perf_stalled + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed decode vectors, backpressure, flush, reset.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        bneq;
    logic        btype;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_fn;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        bneq;
  logic        btype;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [31:0] out_pc;
  logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stalled;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_fn(alu_fn),
    .operandA(operandA), .operandB(operandB), .bneq(bneq), .btype(btype),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_pc(out_pc), .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stalled(perf_stalled)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                              input logic bq, input logic bt, input logic [4:0] rd,
                              input logic wb, input logic [31:0] pc);
    exp_t e;
    e = '{fn: fn, a: a, b: b, bneq: bq, btype: bt, rd: rd, wb: wb, pc: pc, ill: 1'b0};
    return e;
  endfunction

  function automatic exp_t mk_ill(input logic [31:0] pc);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.ill = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Present one instruction and hold it until it is accepted; expectation queued on accept
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    int n;
    in_instr = instr;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: pc 0x%0h never accepted", pc);
    end else begin
      @(posedge clk);
      sb.push_back(e);
      #1;
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t act;
    exp_t req;
    if (rst_n && out_valid && out_ready) begin
      act = {alu_fn, operandA, operandB, bneq, btype, out_rd, out_wb_en, out_pc, out_illegal};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue: pc 0x%0h with empty scoreboard", out_pc);
      end else begin
        req = sb.pop_front();
        if (act !== req) begin
          bad++;
          $display("FAIL issue_pc_%0h: got fn=%0d A=%h B=%h bneq=%b bt=%b rd=%0d wb=%b pc=%h ill=%b want fn=%0d A=%h B=%h bneq=%b bt=%b rd=%0d wb=%b pc=%h ill=%b",
                   req.pc, act.fn, act.a, act.b, act.bneq, act.btype, act.rd, act.wb, act.pc, act.ill,
                   req.fn, req.a, req.b, req.bneq, req.btype, req.rd, req.wb, req.pc, req.ill);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_payload", 64'({alu_fn, operandA, out_wb_en, out_illegal}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    in_instr = 32'h002081B3;
    #1;
    check("rs1_addr", 64'(rs1_addr), 64'd1);
    check("rs2_addr", 64'(rs2_addr), 64'd2);

    // Latency: single add appears on the cycle after acceptance
    send(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 5'd3, 1'b1, 32'h100));
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    idle(2);

    // Directed decode vectors, back-to-back with the execute stage always ready
    send(32'h402081B3, 32'h104, 32'd5, 32'd7, mk(4'd8, 32'd5, 32'd7, 1'b0, 1'b0, 5'd3, 1'b1, 32'h104));
    send(32'h40435293, 32'h108, 32'h80000000, 32'h12345678,
         mk(4'd13, 32'h80000000, 32'd4, 1'b0, 1'b0, 5'd5, 1'b1, 32'h108));
    send(32'h00209463, 32'h10C, 32'd9, 32'd9, mk(4'd8, 32'd9, 32'd9, 1'b1, 1'b1, 5'd0, 1'b0, 32'h10C));
    send(32'h00500093, 32'h110, 32'h0000FFFF, 32'h0000AAAA,
         mk(4'd0, 32'd0, 32'd5, 1'b0, 1'b0, 5'd1, 1'b1, 32'h110));
    send(32'hFFF08113, 32'h114, 32'd3, 32'd0, mk(4'd0, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd2, 1'b1, 32'h114));
    send(32'h02009093, 32'h118, 32'd1, 32'd1, mk_ill(32'h118));
    send(32'h0020D063, 32'h11C, 32'd1, 32'd2, mk(4'd9, 32'd1, 32'd2, 1'b0, 1'b1, 5'd0, 1'b0, 32'h11C));
    send(32'h0020A063, 32'h120, 32'd1, 32'd2, mk_ill(32'h120));
    send(32'h022081B3, 32'h124, 32'd1, 32'd2, mk_ill(32'h124));
    send(32'h00000073, 32'h128, 32'h11, 32'h22, mk_ill(32'h128));
    send(32'h00208033, 32'h12C, 32'd4, 32'd6, mk(4'd0, 32'd4, 32'd6, 1'b0, 1'b0, 5'd0, 1'b0, 32'h12C));
    send(32'h0020D233, 32'h130, 32'd8, 32'd1, mk(4'd5, 32'd8, 32'd1, 1'b0, 1'b0, 5'd4, 1'b1, 32'h130));
    send(32'h4020D233, 32'h134, 32'd8, 32'd1, mk(4'd13, 32'd8, 32'd1, 1'b0, 1'b0, 5'd4, 1'b1, 32'h134));
    send(32'h0020F063, 32'h138, 32'd2, 32'd3, mk(4'd10, 32'd2, 32'd3, 1'b0, 1'b1, 5'd0, 1'b0, 32'h138));
    send(32'h0020E063, 32'h13C, 32'd2, 32'd3, mk(4'd3, 32'd2, 32'd3, 1'b0, 1'b1, 5'd0, 1'b0, 32'h13C));
    send(32'h0020C063, 32'h140, 32'd2, 32'd3, mk(4'd2, 32'd2, 32'd3, 1'b0, 1'b1, 5'd0, 1'b0, 32'h140));
    send(32'h00208063, 32'h144, 32'd2, 32'd3, mk(4'd8, 32'd2, 32'd3, 1'b0, 1'b1, 5'd0, 1'b0, 32'h144));
    idle(3);
    check("drain_after_directed", 64'(sb.size()), 64'd0);

    // Backpressure: two fit (output + skid), third waits, order preserved on release
    out_ready = 1'b0;
    fork
      begin
        send(32'h0020C233, 32'h200, 32'd1, 32'd2, mk(4'd4, 32'd1, 32'd2, 1'b0, 1'b0, 5'd4, 1'b1, 32'h200));
        send(32'h0020E233, 32'h204, 32'd3, 32'd4, mk(4'd6, 32'd3, 32'd4, 1'b0, 1'b0, 5'd4, 1'b1, 32'h204));
        send(32'h0020F233, 32'h208, 32'd5, 32'd6, mk(4'd7, 32'd5, 32'd6, 1'b0, 1'b0, 5'd4, 1'b1, 32'h208));
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_accepted", 64'(sb.size()), 64'd2);
        check("stall_hold_pc", 64'(out_pc), 64'h200);
        out_ready = 1'b1;
      end
    join
    idle(3);
    check("drain_after_stall", 64'(sb.size()), 64'd0);

    // Flush with both entries occupied, then flush racing a fresh accept
    out_ready = 1'b0;
    send(32'h0020B233, 32'h300, 32'd1, 32'd2, mk(4'd3, 32'd1, 32'd2, 1'b0, 1'b0, 5'd4, 1'b1, 32'h300));
    send(32'h0020B233, 32'h304, 32'd1, 32'd2, mk(4'd3, 32'd1, 32'd2, 1'b0, 1'b0, 5'd4, 1'b1, 32'h304));
    in_instr = 32'h002081B3;
    in_pc    = 32'h308;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_pc    = 32'h30C;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_drops_accept", 64'(out_valid), 64'd0);
    idle(3);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(32'h402081B3, 32'h400, 32'd9, 32'd3, mk(4'd8, 32'd9, 32'd3, 1'b0, 1'b0, 5'd3, 1'b1, 32'h400));
    in_valid = 1'b0;
    @(posedge clk); #3;
    check("prereset_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_payload",
          64'({alu_fn, operandA, bneq, btype, out_rd, out_wb_en, out_illegal}), 64'd0);
    check("async_rst_pc_b", 64'({out_pc, operandB}), 64'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
`ifdef ALU_ISSUE_PERF_EN
    check("perf_reset", 64'({perf_issued, perf_stalled}), 64'd0);
`endif
    @(posedge clk); #1;

    // Two issues after three stalled cycles
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500, 32'd1, 32'd1, mk(4'd0, 32'd1, 32'd1, 1'b0, 1'b0, 5'd3, 1'b1, 32'h500));
    send(32'h002081B3, 32'h504, 32'd2, 32'd2, mk(4'd0, 32'd2, 32'd2, 1'b0, 1'b0, 5'd3, 1'b1, 32'h504));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(4);
`ifdef ALU_ISSUE_PERF_EN
    check("perf_stalled", 64'(perf_stalled), 64'd3);
    check("perf_issued", 64'(perf_issued), 64'd2);
`endif
    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
